// File: rtl/register_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// register_sequencer_pkg
// Shared definitions for the register sequencer:
//   - sizing constants (data width, register count, select width, instr width)
//   - instruction field bit positions
//   - opcode and FSM state encodings
//   - helper that turns a register select into a one-hot write mask
// -----------------------------------------------------------------------------
package register_sequencer_pkg;

  localparam int DATA_WIDTH = 4;
  localparam int NUM_REGS   = 4;
  localparam int SEL_W      = $clog2(NUM_REGS);
  localparam int INSTR_W    = 2 + SEL_W + DATA_WIDTH;

  // Instruction layout: [opcode | dst select | immediate/src field].
  localparam int OPC_MSB = INSTR_W - 1;
  localparam int OPC_LSB = INSTR_W - 2;
  localparam int DST_MSB = OPC_LSB - 1;
  localparam int DST_LSB = DATA_WIDTH;
  localparam int IMM_MSB = DATA_WIDTH - 1;
  localparam int IMM_LSB = 0;
  localparam int SRC_MSB = SEL_W - 1;
  localparam int SRC_LSB = 0;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [SEL_W-1:0]      sel_t;
  typedef logic [NUM_REGS-1:0]   mask_t;

  typedef enum logic [1:0] {
    OP_LDI = 2'b00,
    OP_MOV = 2'b01,
    OP_ADD = 2'b10,
    OP_OUT = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_DECODE  = 2'b01,
    ST_EXECUTE = 2'b10,
    ST_WRITE   = 2'b11
  } state_e;

  function automatic mask_t dst_onehot(input sel_t sel);
    mask_t m;
    m      = '0;
    m[sel] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/register_sequencer_if.sv
// -----------------------------------------------------------------------------
// register_sequencer_if
// Groups the instruction handshake and the register-bank bus of the sequencer.
//   instr/instrValid/instrReady : micro-instruction valid/ready handshake
//   regValues                   : packed outputs of the register bank
//   setValue/valueIn            : one-hot load strobes and shared write bus
//   outValue/outValid           : OUT result and its one-cycle pulse
//   carry/busy                  : status
// Modports:
//   slave  - the sequencer
//   master - the environment (instruction source + register bank)
// -----------------------------------------------------------------------------
interface register_sequencer_if;
  import register_sequencer_pkg::*;

  logic [INSTR_W-1:0]             instr;
  logic                           instrValid;
  logic                           instrReady;
  logic [NUM_REGS*DATA_WIDTH-1:0] regValues;
  mask_t                          setValue;
  data_t                          valueIn;
  data_t                          outValue;
  logic                           outValid;
  logic                           carry;
  logic                           busy;

  modport slave (
    input  instr, instrValid, regValues,
    output instrReady, setValue, valueIn, outValue, outValid, carry, busy
  );

  modport master (
    output instr, instrValid, regValues,
    input  instrReady, setValue, valueIn, outValue, outValid, carry, busy
  );

endinterface

// File: rtl/sequencer_alu.sv
// -----------------------------------------------------------------------------
// sequencer_alu
// Purely combinational result computation for one micro-instruction.
//   i_opcode  : instruction opcode
//   i_dst_val : current value of the destination register
//   i_src_val : current value of the source register
//   i_imm     : immediate field
//   o_result  : value to be written (or captured, for OUT)
//   o_carry   : carry out of the ADD (0 for other opcodes)
// -----------------------------------------------------------------------------
module sequencer_alu
  import register_sequencer_pkg::*;
(
  input  opcode_e i_opcode,
  input  data_t   i_dst_val,
  input  data_t   i_src_val,
  input  data_t   i_imm,
  output data_t   o_result,
  output logic    o_carry
);

  logic [DATA_WIDTH:0] w_sum;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_sum    = {1'b0, i_dst_val} + {1'b0, i_src_val};
    o_result = '0;
    o_carry  = 1'b0;
    case (i_opcode)
      OP_LDI: o_result = i_imm;
      OP_MOV: o_result = i_src_val;
      OP_ADD: {o_carry, o_result} = w_sum;
      OP_OUT: o_result = i_dst_val;
      default: ;
    endcase
  end

endmodule

// File: rtl/register_sequencer.sv
// -----------------------------------------------------------------------------
// register_sequencer
// Control unit for the general register bank. Accepts one micro-instruction
// per handshake, walks IDLE -> DECODE -> EXECUTE -> WRITE, and in WRITE drives
// the shared write bus plus the one-hot load strobe of the target register.
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : register_sequencer_if.slave (handshake, bank bus, status)
// Accept at edge N -> strobe during the cycle before edge N+3 -> new register
// content visible after edge N+3; a new instruction can be taken at edge N+4.
// -----------------------------------------------------------------------------
module register_sequencer
  import register_sequencer_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  register_sequencer_if.slave   bus
);

  state_e             r_state;
  state_e             w_next_state;
  logic               r_ready;
  logic               r_carry;
  data_t              r_out_value;
  logic               r_out_valid;

  logic [INSTR_W-1:0] r_instr;
  opcode_e            r_op;
  sel_t               r_dst;
  sel_t               r_src;
  data_t              r_imm;
  mask_t              r_dst_mask;
  data_t              r_result;
  logic               r_carry_pend;

  logic               w_accept;
  data_t              w_dst_val;
  data_t              w_src_val;
  data_t              w_alu_result;
  logic               w_alu_carry;
  mask_t              w_set_value;
  data_t              w_value_in;

  // r_ready already implies IDLE; anything offered in other states is dropped.
  assign w_accept  = r_ready && bus.instrValid;

  assign w_dst_val = bus.regValues[r_dst*DATA_WIDTH +: DATA_WIDTH];
  assign w_src_val = bus.regValues[r_src*DATA_WIDTH +: DATA_WIDTH];

  sequencer_alu u_alu (
    .i_opcode  (r_op),
    .i_dst_val (w_dst_val),
    .i_src_val (w_src_val),
    .i_imm     (r_imm),
    .o_result  (w_alu_result),
    .o_carry   (w_alu_carry)
  );

  // Next state and WRITE-cycle bus drive. The bus is decoded from the state
  // register, so an asynchronous reset silences it immediately.
  always_comb begin
    w_next_state = r_state;
    w_set_value  = '0;
    w_value_in   = '0;
    case (r_state)
      ST_IDLE:    if (w_accept) w_next_state = ST_DECODE;
      ST_DECODE:  w_next_state = ST_EXECUTE;
      ST_EXECUTE: w_next_state = ST_WRITE;
      ST_WRITE: begin
        w_next_state = ST_IDLE;
        w_value_in   = r_result;
        if (r_op != OP_OUT) w_set_value = r_dst_mask;
      end
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b0;
      r_carry     <= 1'b0;
      r_out_value <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      // Registered ready: high exactly while the FSM sits in IDLE.
      r_ready     <= (w_next_state == ST_IDLE);
      r_out_valid <= 1'b0;
      if (r_state == ST_EXECUTE && r_op == OP_OUT) begin
        r_out_value <= w_alu_result;
        r_out_valid <= 1'b1;
      end
      if (r_state == ST_WRITE && r_op == OP_ADD) r_carry <= r_carry_pend;
    end
  end

  // NOTE: the instruction/decode/result registers carry no reset; they are
  // only consumed in states that can be reached after they were loaded.
  always_ff @(posedge clock) begin
    if (w_accept) r_instr <= bus.instr;
    if (r_state == ST_DECODE) begin
      r_op       <= opcode_e'(r_instr[OPC_MSB:OPC_LSB]);
      r_dst      <= r_instr[DST_MSB:DST_LSB];
      r_src      <= r_instr[SRC_MSB:SRC_LSB];
      r_imm      <= r_instr[IMM_MSB:IMM_LSB];
      r_dst_mask <= dst_onehot(r_instr[DST_MSB:DST_LSB]);
    end
    if (r_state == ST_EXECUTE) begin
      r_result     <= w_alu_result;
      r_carry_pend <= w_alu_carry;
    end
  end

  assign bus.instrReady = r_ready;
  assign bus.setValue   = w_set_value;
  assign bus.valueIn    = w_value_in;
  assign bus.outValue   = r_out_value;
  assign bus.outValid   = r_out_valid;
  assign bus.carry      = r_carry;
  assign bus.busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_register_sequencer.sv
// -----------------------------------------------------------------------------
// tb_register_sequencer
// Surrounds the sequencer with four 4-bit registers and compares every cycle
// against a transaction-level model: an accepted instruction's effect is
// computed from the opcode rules at accept time and then scheduled by its
// distance (in edges) from the accept edge.
// -----------------------------------------------------------------------------
module tb_register_sequencer;

  logic clock;
  logic reset;

  register_sequencer_if bus_if ();

  register_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register bank: loads from the write bus on its strobe, never reset.
  logic [3:0] bank [4] = '{default: 4'h0};
  always @(posedge clock) begin
    for (int i = 0; i < 4; i++)
      if (bus_if.setValue[i]) bank[i] <= bus_if.valueIn;
  end
  assign bus_if.regValues = {bank[3], bank[2], bank[1], bank[0]};

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // ---------------- reference model ----------------
  int         cyc      = 0;
  int         m_acc    = -100;
  bit         m_pend   = 0;
  logic       m_ready  = 1'b0;
  logic [3:0] m_regs [4] = '{default: 4'h0};
  logic       m_carry  = 1'b0;
  logic [3:0] m_outv   = 4'h0;
  int         m_op;
  int         m_dst;
  logic [3:0] m_res;
  logic       m_cnew;
  logic       drv_valid;
  logic [7:0] drv_instr;

  task automatic model_reset();
    m_pend  = 0;
    m_ready = 1'b0;
    m_carry = 1'b0;
    m_outv  = 4'h0;
  endtask

  task automatic model_edge();
    int src;
    int sum;
    int d;
    if (reset === 1'b0) begin
      m_ready = 1'b0;
    end else begin
      if (m_pend) begin
        d = cyc - m_acc;
        if (d == 2 && m_op == 3) m_outv = m_res;
        if (d == 3) begin
          if (m_op != 3) m_regs[m_dst] = m_res;
          if (m_op == 2) m_carry = m_cnew;
          m_pend = 0;
        end
      end
      if (m_ready && drv_valid) begin
        m_op   = int'(drv_instr[7:6]);
        m_dst  = int'(drv_instr[5:4]);
        src    = int'(drv_instr[1:0]);
        m_cnew = 1'b0;
        case (m_op)
          0: m_res = drv_instr[3:0];
          1: m_res = m_regs[src];
          2: begin
            sum    = int'(m_regs[m_dst]) + int'(m_regs[src]);
            m_res  = 4'(sum % 16);
            m_cnew = (sum >= 16);
          end
          default: m_res = m_regs[m_dst];
        endcase
        m_pend = 1;
        m_acc  = cyc;
      end
      m_ready = !m_pend;
    end
  endtask

  task automatic compare_all();
    int         d;
    bit         w;
    logic [3:0] exp_set;
    logic [3:0] exp_vin;
    d       = cyc - m_acc;
    w       = m_pend && (d == 2);
    exp_set = (w && m_op != 3) ? 4'(1 << m_dst) : 4'h0;
    exp_vin = w ? m_res : 4'h0;
    check("instrReady", 32'(bus_if.instrReady), 32'(m_ready));
    check("busy",       32'(bus_if.busy),       32'(m_pend));
    check("setValue",   32'(bus_if.setValue),   32'(exp_set));
    check("valueIn",    32'(bus_if.valueIn),    32'(exp_vin));
    check("outValid",   32'(bus_if.outValid),   32'(w && m_op == 3));
    check("outValue",   32'(bus_if.outValue),   32'(m_outv));
    check("carry",      32'(bus_if.carry),      32'(m_carry));
    for (int i = 0; i < 4; i++)
      check($sformatf("reg%0d", i), 32'(bank[i]), 32'(m_regs[i]));
  endtask

  // One clock: drive inputs, advance to the edge, update model, sample away
  // from the edge.
  task automatic step(input logic v, input logic [7:0] ins);
    drv_valid         = v;
    drv_instr         = ins;
    bus_if.instrValid = v;
    bus_if.instr      = ins;
    @(posedge clock);
    cyc++;
    model_edge();
    @(negedge clock);
    compare_all();
  endtask

  // Issue one instruction and let it retire (register content visible after).
  task automatic run_instr(input logic [7:0] ins);
    for (int k = 0; k < 8 && !m_ready; k++) step(1'b0, 8'h00);
    check("ready_before_issue", 32'(bus_if.instrReady), 32'd1);
    step(1'b1, ins);
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00);
  endtask

  initial begin
    bus_if.instrValid = 1'b0;
    bus_if.instr      = 8'h00;
    drv_valid         = 1'b0;
    drv_instr         = 8'h00;

    // Reset: asserted asynchronously, held three edges.
    reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    #1;
    check("rst_ready",    32'(bus_if.instrReady), 32'd0);
    check("rst_setValue", 32'(bus_if.setValue),   32'd0);
    check("rst_valueIn",  32'(bus_if.valueIn),    32'd0);
    check("rst_busy",     32'(bus_if.busy),       32'd0);
    check("rst_outValid", 32'(bus_if.outValid),   32'd0);
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00);
    reset = 1'b1;
    step(1'b0, 8'h00);
    check("ready_after_release", 32'(bus_if.instrReady), 32'd1);

    // LDI r2,0xA with explicit latency checks.
    step(1'b1, 8'h2A);
    check("ldi_busy_n1",  32'(bus_if.busy),     32'd1);
    check("ldi_set_n1",   32'(bus_if.setValue), 32'd0);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    check("ldi_set_n3",   32'(bus_if.setValue), 32'h4);
    check("ldi_vin_n3",   32'(bus_if.valueIn),  32'hA);
    step(1'b0, 8'h00);
    check("ldi_set_n4",   32'(bus_if.setValue), 32'd0);
    check("ldi_busy_n4",  32'(bus_if.busy),     32'd0);
    check("ldi_reg2",     32'(bank[2]),         32'hA);

    // ADD with carry, ADD self-doubling.
    run_instr(8'h09);
    run_instr(8'h18);
    run_instr(8'h81);
    check("add_r0r1_val",   32'(bank[0]),      32'h1);
    check("add_r0r1_carry", 32'(bus_if.carry), 32'd1);
    run_instr(8'h95);
    check("add_r1r1_val",   32'(bank[1]),      32'h0);
    check("add_r1r1_carry", 32'(bus_if.carry), 32'd1);
    run_instr(8'h80);
    check("add_r0r0_val",   32'(bank[0]),      32'h2);
    check("add_r0r0_carry", 32'(bus_if.carry), 32'd0);

    // MOV then OUT; MOV onto itself still strobes (model checks strobe).
    run_instr(8'h05);
    run_instr(8'h70);
    check("mov_r3", 32'(bank[3]), 32'h5);
    run_instr(8'hF0);
    check("out_value", 32'(bus_if.outValue), 32'h5);
    run_instr(8'h6A);
    check("mov_self_r2", 32'(bank[2]), 32'hA);

    // Instructions offered while busy are dropped.
    step(1'b1, 8'h13);
    step(1'b1, 8'h2F);
    step(1'b1, 8'h3E);
    step(1'b1, 8'h0C);
    step(1'b0, 8'h00);
    check("hold_r1", 32'(bank[1]), 32'h3);
    check("hold_r2", 32'(bank[2]), 32'hA);
    check("hold_r3", 32'(bank[3]), 32'h5);
    check("hold_r0", 32'(bank[0]), 32'h5);

    // Reset during EXECUTE of an ADD that would carry.
    run_instr(8'h07);
    run_instr(8'h19);
    step(1'b1, 8'h81);
    step(1'b0, 8'h00);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("midrst_busy",     32'(bus_if.busy),       32'd0);
    check("midrst_setValue", 32'(bus_if.setValue),   32'd0);
    check("midrst_ready",    32'(bus_if.instrReady), 32'd0);
    check("midrst_carry",    32'(bus_if.carry),      32'd0);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    reset = 1'b1;
    step(1'b0, 8'h00);
    check("midrst_r0_kept", 32'(bank[0]),      32'h7);
    check("midrst_carry2",  32'(bus_if.carry), 32'd0);
    run_instr(8'h3C);
    check("post_rst_ldi", 32'(bank[3]), 32'hC);

    // Randomized traffic, checked every cycle against the model.
    for (int k = 0; k < 400; k++)
      step(($urandom % 3) != 0, 8'($urandom));
    for (int k = 0; k < 4; k++) step(1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Safety net so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
